// File: rtl/gelato_fetch_scheduler.sv
// gelato_fetch_scheduler: round-robin per-warp instruction fetch request scheduler
// Ports: clk/rst_n (async active-low) clock and reset; rdy global enable (low freezes everything);
//   launch_* starts a warp at a PC; update_* writes back a warp's next PC and clears its pending fetch;
//   exit_* retires a warp; fetch_valid/fetch_ready/fetch_pc/fetch_warp registered fetch offer and
//   handshake; active_count number of active warps.
module gelato_fetch_scheduler #(
    parameter int NUM_WARPS = 8,
    parameter int PC_WIDTH  = 32,
    localparam int WARP_W   = $clog2(NUM_WARPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                launch_valid,
    input  logic [WARP_W-1:0]   launch_warp,
    input  logic [PC_WIDTH-1:0] launch_pc,
    input  logic                update_valid,
    input  logic [WARP_W-1:0]   update_warp,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic                exit_valid,
    input  logic [WARP_W-1:0]   exit_warp,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic [WARP_W-1:0]   fetch_warp,
    output logic [WARP_W:0]     active_count
);
    logic [NUM_WARPS-1:0] active, pending, active_nx, pending_nx, elig;
    logic [PC_WIDTH-1:0]  pc [NUM_WARPS];
    logic [WARP_W-1:0]    rr_ptr, pick, idx;
    logic [WARP_W:0]      count_nx;
    logic                 found, xfer, launch_ok, update_ok, exit_ok, exit_hit;

    assign xfer      = rdy & fetch_valid & fetch_ready;
    assign launch_ok = launch_valid & ~active[launch_warp];
    assign update_ok = update_valid & active[update_warp];
    assign exit_ok   = exit_valid & active[exit_warp];
    assign exit_hit  = exit_ok & (exit_warp == fetch_warp);

    // Exit is applied last so it wins over update, launch and a same-edge transfer.
    always_comb begin
        active_nx  = active;
        pending_nx = pending;
        if (launch_ok) begin
            active_nx[launch_warp]  = 1'b1;
            pending_nx[launch_warp] = 1'b0;
        end
        if (update_ok) pending_nx[update_warp] = 1'b0;
        if (xfer) pending_nx[fetch_warp] = 1'b1;
        if (exit_ok) begin
            active_nx[exit_warp]  = 1'b0;
            pending_nx[exit_warp] = 1'b0;
        end
        count_nx = '0;
        for (int i = 0; i < NUM_WARPS; i++)
            count_nx = count_nx + (WARP_W+1)'(active_nx[i]);
    end

    // Pick uses pre-edge state; the warp handed off this edge is not yet pending, so mask it.
    always_comb begin
        elig = active & ~pending;
        if (xfer) elig[fetch_warp] = 1'b0;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rr_ptr + WARP_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= '0;
            pending      <= '0;
            rr_ptr       <= '0;
            fetch_valid  <= 1'b0;
            fetch_pc     <= '0;
            fetch_warp   <= '0;
            active_count <= '0;
            for (int i = 0; i < NUM_WARPS; i++) pc[i] <= '0;
        end else if (rdy) begin
            active       <= active_nx;
            pending      <= pending_nx;
            active_count <= count_nx;
            if (launch_ok) pc[launch_warp] <= launch_pc;
            if (update_ok) pc[update_warp] <= update_pc;
            if (xfer) rr_ptr <= fetch_warp + 1'b1;
            if (xfer || !fetch_valid) begin
                fetch_valid <= found;
                fetch_pc    <= pc[pick];
                fetch_warp  <= pick;
            end else if (exit_hit) begin
                fetch_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// tb_gelato_fetch_scheduler: directed self-checking bench for gelato_fetch_scheduler
module tb_gelato_fetch_scheduler;
    logic        clk = 0, rst_n = 0, rdy = 1;
    logic        launch_valid = 0, update_valid = 0, exit_valid = 0, fetch_ready = 0;
    logic [2:0]  launch_warp = 0, update_warp = 0, exit_warp = 0;
    logic [31:0] launch_pc = 0, update_pc = 0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [2:0]  fetch_warp;
    logic [3:0]  active_count;
    int checks = 0, failures = 0;

    gelato_fetch_scheduler dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .launch_valid(launch_valid), .launch_warp(launch_warp), .launch_pc(launch_pc),
        .update_valid(update_valid), .update_warp(update_warp), .update_pc(update_pc),
        .exit_valid(exit_valid), .exit_warp(exit_warp),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_warp(fetch_warp), .active_count(active_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 0; rdy = 1; fetch_ready = 0;
        launch_valid = 0; update_valid = 0; exit_valid = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic launch(input logic [2:0] w, input logic [31:0] p);
        launch_valid = 1; launch_warp = w; launch_pc = p;
        @(negedge clk);
        launch_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fetch_valid, fetch_pc, fetch_warp, active_count} !== 40'h0) begin
            failures++;
            $display("FAIL reset_state got fv=%0b pc=%h w=%0d cnt=%0d want all zero",
                     fetch_valid, fetch_pc, fetch_warp, active_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        fetch_ready = 1;
        launch(3'd0, 32'h100);
        checks++;
        if (fetch_valid !== 1'b0 || active_count !== 4'd1) begin
            failures++;
            $display("FAIL single_edge1 got fv=%0b cnt=%0d want fv=0 cnt=1", fetch_valid, active_count);
        end
        @(negedge clk);
        checks++;
        if ({fetch_valid, fetch_warp, fetch_pc} !== {1'b1, 3'd0, 32'h100}) begin
            failures++;
            $display("FAIL single_offer got fv=%0b w=%0d pc=%h want 1/0/100", fetch_valid, fetch_warp, fetch_pc);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b0) begin
                failures++;
                $display("FAIL single_no_reoffer cycle %0d got fv=%0b want 0", i, fetch_valid);
            end
        end
        update_valid = 1; update_warp = 0; update_pc = 32'h104;
        @(negedge clk);
        update_valid = 0;
        @(negedge clk);
        checks++;
        if ({fetch_valid, fetch_warp, fetch_pc} !== {1'b1, 3'd0, 32'h104}) begin
            failures++;
            $display("FAIL single_reoffer got fv=%0b w=%0d pc=%h want 1/0/104", fetch_valid, fetch_warp, fetch_pc);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_w [6] = '{3'd1, 3'd2, 3'd5, 3'd1, 3'd2, 3'd5};
        logic [31:0] exp_p [6] = '{32'h200, 32'h300, 32'h500, 32'h204, 32'h304, 32'h504};
        logic        prev_g = 0;
        logic [2:0]  prev_w = 0;
        logic [31:0] prev_p = 0;
        int n = 0;
        do_reset();
        launch(3'd1, 32'h200);
        launch(3'd2, 32'h300);
        launch(3'd5, 32'h500);
        fetch_ready = 1;
        for (int c = 0; c < 20 && n < 6; c++) begin
            update_valid = prev_g; update_warp = prev_w; update_pc = prev_p + 32'd4;
            prev_g = fetch_valid;
            prev_w = fetch_warp;
            prev_p = fetch_pc;
            if (prev_g) begin
                checks++;
                if (fetch_warp !== exp_w[n] || fetch_pc !== exp_p[n]) begin
                    failures++;
                    $display("FAIL rr_grant%0d got w=%0d pc=%h want w=%0d pc=%h",
                             n, fetch_warp, fetch_pc, exp_w[n], exp_p[n]);
                end
                n++;
            end
            @(negedge clk);
        end
        update_valid = 0; fetch_ready = 0;
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL rr_grant_count got %0d want 6", n);
        end
    endtask

    task automatic test_stall_exit();
        do_reset();
        launch(3'd3, 32'h330);
        @(negedge clk);
        checks++;
        if ({fetch_valid, fetch_warp, fetch_pc} !== {1'b1, 3'd3, 32'h330}) begin
            failures++;
            $display("FAIL stall_offer got fv=%0b w=%0d pc=%h want 1/3/330", fetch_valid, fetch_warp, fetch_pc);
        end
        launch(3'd6, 32'h660);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({fetch_valid, fetch_warp, fetch_pc} !== {1'b1, 3'd3, 32'h330}) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got fv=%0b w=%0d pc=%h want 1/3/330",
                         i, fetch_valid, fetch_warp, fetch_pc);
            end
            @(negedge clk);
        end
        checks++;
        if (active_count !== 4'd2) begin
            failures++;
            $display("FAIL stall_count got %0d want 2", active_count);
        end
        exit_valid = 1; exit_warp = 3;
        @(negedge clk);
        exit_valid = 0;
        checks++;
        if (fetch_valid !== 1'b0 || active_count !== 4'd1) begin
            failures++;
            $display("FAIL exit_offered got fv=%0b cnt=%0d want fv=0 cnt=1", fetch_valid, active_count);
        end
        @(negedge clk);
        checks++;
        if ({fetch_valid, fetch_warp, fetch_pc} !== {1'b1, 3'd6, 32'h660}) begin
            failures++;
            $display("FAIL exit_reload got fv=%0b w=%0d pc=%h want 1/6/660", fetch_valid, fetch_warp, fetch_pc);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        rdy = 0;
        launch(3'd4, 32'h440);
        @(negedge clk);
        rdy = 1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || active_count !== 4'd0) begin
            failures++;
            $display("FAIL rdy_launch_ignored got fv=%0b cnt=%0d want 0/0", fetch_valid, active_count);
        end
        launch(3'd4, 32'h440);
        @(negedge clk);
        rdy = 0; fetch_ready = 1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({fetch_valid, fetch_warp, fetch_pc, active_count} !== {1'b1, 3'd4, 32'h440, 4'd1}) begin
            failures++;
            $display("FAIL rdy_hold_offer got fv=%0b w=%0d pc=%h cnt=%0d want 1/4/440/1",
                     fetch_valid, fetch_warp, fetch_pc, active_count);
        end
        rdy = 1; fetch_ready = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        launch(3'd2, 32'h2a0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({fetch_valid, fetch_pc, fetch_warp, active_count} !== 40'h0) begin
            failures++;
            $display("FAIL reset_async got fv=%0b pc=%h w=%0d cnt=%0d want all zero",
                     fetch_valid, fetch_pc, fetch_warp, active_count);
        end
        @(negedge clk);
        rst_n = 1; fetch_ready = 1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b0 || active_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_no_grant got fv=%0b cnt=%0d want 0/0", fetch_valid, active_count);
        end
        launch(3'd2, 32'h20);
        @(negedge clk);
        checks++;
        if ({fetch_valid, fetch_warp, fetch_pc} !== {1'b1, 3'd2, 32'h20}) begin
            failures++;
            $display("FAIL reset_relaunch got fv=%0b w=%0d pc=%h want 1/2/20", fetch_valid, fetch_warp, fetch_pc);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_stall_exit();
        test_rdy_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
